// File: rtl/exp7_arbitro_saida.sv
// Output arbiter: shares one LED bank and buzzer between memory playback and player echo.
// Define ARBITRO_PREEMPT_EN to let an echo request abort a memory display in progress.
module exp7_arbitro_saida #(
    parameter int unsigned DURACAO = 500,
    parameter int unsigned PAUSA   = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_mem,
    input  logic [3:0] dado_mem,
    input  logic       req_jog,
    input  logic [3:0] dado_jog,
    output logic       gnt_mem,
    output logic       gnt_jog,
    output logic [3:0] leds,
    output logic       toca,
    output logic       done,
    output logic       abortado,
    output logic       ocupado,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StGrantMem = 3'd1,
        StGrantJog = 3'd2,
        StShow     = 3'd3,
        StGap      = 3'd4
    } estado_t;

    localparam logic [15:0] ShowLast = 16'(DURACAO - 1);
    localparam logic [15:0] GapLast  = 16'(PAUSA - 1);

    estado_t     estado_q, estado_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  padrao_q, padrao_d;
    logic        dono_q, dono_d;      // 0 = mem, 1 = jog
    logic        ultimo_q, ultimo_d;  // last requester served, same encoding
    logic        preempt;

`ifdef ARBITRO_PREEMPT_EN
    assign preempt = (estado_q == StShow) && !dono_q && req_jog && !reset;
`else
    assign preempt = 1'b0;
`endif

    assign abortado = preempt;

    // The pattern is captured on the edge that enters GRANT, so a one-cycle request suffices.
    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        padrao_d = padrao_q;
        dono_d   = dono_q;
        ultimo_d = ultimo_q;
        case (estado_q)
            StIdle: begin
                if (req_mem && (!req_jog || ultimo_q)) begin
                    estado_d = StGrantMem;
                    padrao_d = dado_mem;
                    dono_d   = 1'b0;
                    ultimo_d = 1'b0;
                    timer_d  = '0;
                end else if (req_jog) begin
                    estado_d = StGrantJog;
                    padrao_d = dado_jog;
                    dono_d   = 1'b1;
                    ultimo_d = 1'b1;
                    timer_d  = '0;
                end
            end
            StGrantMem, StGrantJog: begin
                estado_d = StShow;
                timer_d  = '0;
            end
            StShow: begin
                if (preempt) begin
                    estado_d = StGrantJog;
                    padrao_d = dado_jog;
                    dono_d   = 1'b1;
                    ultimo_d = 1'b1;
                    timer_d  = '0;
                end else if (timer_q == ShowLast) begin
                    estado_d = StGap;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StGap: begin
                if (timer_q == GapLast) begin
                    estado_d = StIdle;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                estado_d = StIdle;
                timer_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= StIdle;
            timer_q   <= '0;
            padrao_q  <= '0;
            dono_q    <= 1'b0;
            ultimo_q  <= 1'b0;
            gnt_mem   <= 1'b0;
            gnt_jog   <= 1'b0;
            leds      <= '0;
            toca      <= 1'b0;
            done      <= 1'b0;
            ocupado   <= 1'b0;
            db_estado <= '0;
        end else begin
            estado_q  <= estado_d;
            timer_q   <= timer_d;
            padrao_q  <= padrao_d;
            dono_q    <= dono_d;
            ultimo_q  <= ultimo_d;
            gnt_mem   <= (estado_d == StGrantMem);
            gnt_jog   <= (estado_d == StGrantJog);
            leds      <= (estado_d == StShow) ? padrao_d : 4'b0000;
            toca      <= (estado_d == StShow);
            done      <= (estado_d == StGap) && (timer_d == GapLast);
            ocupado   <= (estado_d != StIdle);
            db_estado <= estado_d;
        end
    end

endmodule

// File: tb/tb_exp7_arbitro_saida.sv
// Directed bench for exp7_arbitro_saida with DURACAO=4, PAUSA=2.
module tb_exp7_arbitro_saida;

    localparam int unsigned DUR = 4;
    localparam int unsigned PAU = 2;
`ifdef ARBITRO_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       req_mem, req_jog;
    logic [3:0] dado_mem, dado_jog;
    logic       gnt_mem, gnt_jog, toca, done, abortado, ocupado;
    logic [3:0] leds;
    logic [2:0] db_estado;

    int total = 0;
    int bad   = 0;

    exp7_arbitro_saida #(.DURACAO(DUR), .PAUSA(PAU)) dut (
        .clock(clock), .reset(reset),
        .req_mem(req_mem), .dado_mem(dado_mem),
        .req_jog(req_jog), .dado_jog(dado_jog),
        .gnt_mem(gnt_mem), .gnt_jog(gnt_jog),
        .leds(leds), .toca(toca), .done(done), .abortado(abortado),
        .ocupado(ocupado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // {gnt_mem, gnt_jog, leds, toca, done, abortado, ocupado, db_estado}
    function automatic logic [12:0] snap();
        return {gnt_mem, gnt_jog, leds, toca, done, abortado, ocupado, db_estado};
    endfunction

    function automatic logic [12:0] mk(logic gm, logic gj, logic [3:0] l, logic t, logic d,
                                       logic a, logic o, logic [2:0] s);
        return {gm, gj, l, t, d, a, o, s};
    endfunction

    task automatic test_reset();
        reset = 1'b1; req_mem = 1'b0; req_jog = 1'b0; dado_mem = '0; dado_jog = '0;
        step();
        step();
        total++;
        if (snap() !== 13'd0) begin
            bad++;
            $display("FAIL reset_state: got %b want %b", snap(), 13'd0);
        end
        reset = 1'b0;
        step();
        total++;
        if (snap() !== 13'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want %b", snap(), 13'd0);
        end
    endtask

    task automatic test_single();
        logic [12:0] e;
        req_mem = 1'b1; dado_mem = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1)      e = mk(1, 0, 4'b0000, 0, 0, 0, 1, 3'd1);
            else if (k <= 5) e = mk(0, 0, 4'b0001, 1, 0, 0, 1, 3'd3);
            else if (k == 6) e = mk(0, 0, 4'b0000, 0, 0, 0, 1, 3'd4);
            else if (k == 7) e = mk(0, 0, 4'b0000, 0, 1, 0, 1, 3'd4);
            else             e = 13'd0;
            total++;
            if (snap() !== e) begin
                bad++;
                $display("FAIL single_mem cycle t+%0d: got %b want %b", k, snap(), e);
            end
            if (k == 1) begin
                req_mem = 1'b0;
                dado_mem = 4'b1111;
            end
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int overlap = 0;
        logic [3:0] ord = '0;
        int at [4];
        logic [3:0] l2 = '0, l10 = '0;
        reset = 1'b1; req_mem = 1'b1; req_jog = 1'b1;
        dado_mem = 4'b0001; dado_jog = 4'b1000;
        step();
        total++;
        if (snap() !== 13'd0) begin
            bad++;
            $display("FAIL rr_no_grant_in_reset: got %b want %b", snap(), 13'd0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (gnt_mem && gnt_jog) overlap++;
            if ((gnt_mem || gnt_jog) && n < 4) begin
                ord[n] = gnt_jog;
                at[n] = k;
                n++;
                if (n == 4) begin
                    req_mem = 1'b0;
                    req_jog = 1'b0;
                end
            end
            if (k == 2) l2 = leds;
            if (k == 10) l10 = leds;
        end
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL rr_grant_count: got %0d want 4", n);
        end
        total++;
        if (ord !== 4'b0101) begin
            bad++;
            $display("FAIL rr_order (bit i=1 means jog): got %b want 0101", ord);
        end
        total++;
        if (overlap !== 0) begin
            bad++;
            $display("FAIL rr_overlap: got %0d want 0", overlap);
        end
        total++;
        if (n == 4 && (at[0] != 1 || at[1] != 9 || at[2] != 17 || at[3] != 25)) begin
            bad++;
            $display("FAIL rr_grant_cycles: got %0d %0d %0d %0d want 1 9 17 25",
                     at[0], at[1], at[2], at[3]);
        end
        total++;
        if ({l2, l10} !== 8'b1000_0001) begin
            bad++;
            $display("FAIL rr_patterns: got %b/%b want 1000/0001", l2, l10);
        end
        total++;
        if (db_estado !== 3'd0) begin
            bad++;
            $display("FAIL rr_end_idle: got %0d want 0", db_estado);
        end
    endtask

    task automatic test_data_hold();
        req_jog = 1'b1; dado_jog = 4'b0010;
        step();
        total++;
        if (gnt_jog !== 1'b1 || db_estado !== 3'd2) begin
            bad++;
            $display("FAIL hold_grant: got gnt_jog=%b st=%0d want 1/2", gnt_jog, db_estado);
        end
        req_jog = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            step();
            if (k == 2) dado_jog = 4'b1000;
            total++;
            if (leds !== 4'b0010 || toca !== 1'b1) begin
                bad++;
                $display("FAIL hold_leds cycle %0d: got %b/%b want 0010/1", k, leds, toca);
            end
        end
        step(); step(); step();
        total++;
        if (db_estado !== 3'd0) begin
            bad++;
            $display("FAIL hold_end_idle: got %0d want 0", db_estado);
        end
    endtask

    task automatic test_preempt();
        int gj_at = -1;
        int dones = 0, abs = 0, n0010 = 0, n0100 = 0;
        req_mem = 1'b1; dado_mem = 4'b0100;
        step();
        req_mem = 1'b0;
        step();
        step();
        req_jog = 1'b1; dado_jog = 4'b0010;
        #1;
        total++;
        if (abortado !== PRE) begin
            bad++;
            $display("FAIL preempt_abortado: got %b want %b", abortado, PRE);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done) dones++;
            if (abortado) abs++;
            if (leds == 4'b0010) n0010++;
            if (leds == 4'b0100) n0100++;
            if (gnt_jog && gj_at < 0) begin
                gj_at = k;
                req_jog = 1'b0;
            end
        end
        total++;
        if (gj_at !== (PRE ? 1 : 6)) begin
            bad++;
            $display("FAIL preempt_gnt_jog_cycle: got %0d want %0d", gj_at, PRE ? 1 : 6);
        end
        total++;
        if (dones !== (PRE ? 1 : 2)) begin
            bad++;
            $display("FAIL preempt_done_count: got %0d want %0d", dones, PRE ? 1 : 2);
        end
        total++;
        if (abs !== 0) begin
            bad++;
            $display("FAIL preempt_extra_abortado: got %0d want 0", abs);
        end
        total++;
        if (n0010 !== 4 || n0100 !== (PRE ? 0 : 2)) begin
            bad++;
            $display("FAIL preempt_patterns: got jog=%0d mem=%0d want 4/%0d",
                     n0010, n0100, PRE ? 0 : 2);
        end
        total++;
        if (db_estado !== 3'd0) begin
            bad++;
            $display("FAIL preempt_end_idle: got %0d want 0", db_estado);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        req_mem = 1'b1; dado_mem = 4'b0001;
        step();
        req_mem = 1'b0;
        step();
        step();
        total++;
        if (leds !== 4'b0001 || db_estado !== 3'd3) begin
            bad++;
            $display("FAIL midreset_show: got %b/%0d want 0001/3", leds, db_estado);
        end
        reset = 1'b1;
        step();
        total++;
        if (snap() !== 13'd0) begin
            bad++;
            $display("FAIL midreset_state: got %b want %b", snap(), 13'd0);
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done) dones++;
        end
        total++;
        if (dones !== 0 || db_estado !== 3'd0) begin
            bad++;
            $display("FAIL midreset_no_done: got done=%0d st=%0d want 0/0", dones, db_estado);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_data_hold();
        test_preempt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
